pulse_stretch_moore_amisha: RTL

PULSE_STRETCH_MOORE_AMISHA -- requirements
Module: pulse_stretch_moore_amisha

---
 rtl/pulse_stretch_moore_amisha.sv | 105 ++++++++++
 1 files changed

// File: rtl/pulse_stretch_moore_amisha.sv
// Purpose: stretches a one-cycle tick into a WIDTH-cycle level, then enforces a GAP-cycle low guard time.
// Latency: one cycle from tick to level; drop strobe and drop count update one cycle after the rejected tick.
// Backpressure: none; ticks arriving while busy are dropped (or restart the pulse when RETRIG=1) and counted.
module pulse_stretch_moore_amisha #(
    parameter int WIDTH  = 4,
    parameter int GAP    = 2,
    parameter int RETRIG = 0,
    parameter int CW     = 8
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic       tick_amisha,
    output logic       level_amisha,
    output logic       busy_amisha,
    output logic       drop_amisha,
    output logic [7:0] drop_cnt_amisha
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HIGH  = 2'b01,
        GAP_S = 2'b10
    } state_t;

    // Counter reload values; the counter runs N-1 down to 0, so N cycles per phase.
    localparam logic [CW-1:0] W_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] G_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    // Next-state, counter and drop decision; ticks are only ever accepted in IDLE
    // (or reload the pulse in HIGH when retriggering is enabled).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (tick_amisha) begin
                    state_d = HIGH;
                    cnt_d   = W_LOAD;
                end
            end
            HIGH: begin
                if (tick_amisha && (RETRIG != 0)) begin
                    cnt_d = W_LOAD;
                end else begin
                    // A rejected tick leaves the countdown running untouched.
                    drop_d = tick_amisha;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (GAP > 0) begin
                        state_d = GAP_S;
                        cnt_d   = G_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP_S: begin
                drop_d = tick_amisha;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Unused encoding 2'b11 recovers to IDLE on the next edge.
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State, counter and drop bookkeeping registers; reset wins over any tick.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign level_amisha    = (state_q == HIGH);
    assign busy_amisha     = (state_q != IDLE);
    assign drop_amisha     = drop_q;
    assign drop_cnt_amisha = drop_cnt_q;

endmodule
